// File: rtl/uart_rx32.sv
// 32-bit-word UART receiver: start bit, 32 data bits LSB first, stop bit.
// Define UART_RX32_PARITY_EN to add an even-parity bit before the stop bit.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | line idle, waiting for rx_s to fall
// START     | half a bit in, re-check start bit to reject glitches
// DATA      | sample 32 data bits at mid-bit
// PARITY    | sample even-parity bit (UART_RX32_PARITY_EN only)
// STOP      | sample stop bit, issue result pulse
// WAIT_HIGH | after a framing error, wait for the line to go high
module uart_rx32 #(
    parameter int CLKS_PER_BIT = 1042
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        rx,
    output logic [31:0] rx_data,
    output logic        rx_done,
    output logic        rx_busy,
    output logic        frame_err,
    output logic        parity_err
);

    localparam int CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int HALF = CLKS_PER_BIT / 2;

    localparam logic [CW-1:0] FULL_TC = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_TC = CW'(HALF - 1);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_STOP      = 3'd3;
    localparam logic [2:0] ST_WAIT_HIGH = 3'd4;
`ifdef UART_RX32_PARITY_EN
    localparam logic [2:0] ST_PARITY    = 3'd5;
`endif

    logic          rx_meta;
    logic          rx_s;
    logic [2:0]    state;
    logic [CW-1:0] clk_cnt;
    logic [5:0]    bit_cnt;
    logic [31:0]   shreg;
`ifdef UART_RX32_PARITY_EN
    logic          par_bit;
    logic          par_err_q;
`endif

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // clk_cnt is a down-counter; each state acts when it reaches terminal count 0.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state     <= ST_IDLE;
            clk_cnt   <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX32_PARITY_EN
            par_bit   <= 1'b0;
            par_err_q <= 1'b0;
`endif
        end else begin
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX32_PARITY_EN
            par_err_q <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (!rx_s) begin
                        clk_cnt <= HALF_TC;
                        state   <= ST_START;
                    end
                end
                ST_START: begin
                    if (clk_cnt != '0) begin
                        clk_cnt <= clk_cnt - CW'(1);
                    end else if (rx_s) begin
                        state <= ST_IDLE;
                    end else begin
                        clk_cnt <= FULL_TC;
                        bit_cnt <= '0;
                        state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (clk_cnt != '0) begin
                        clk_cnt <= clk_cnt - CW'(1);
                    end else begin
                        clk_cnt               <= FULL_TC;
                        shreg[bit_cnt[4:0]]   <= rx_s;
                        if (bit_cnt == 6'd31) begin
`ifdef UART_RX32_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 6'd1;
                        end
                    end
                end
`ifdef UART_RX32_PARITY_EN
                ST_PARITY: begin
                    if (clk_cnt != '0) begin
                        clk_cnt <= clk_cnt - CW'(1);
                    end else begin
                        par_bit <= rx_s;
                        clk_cnt <= FULL_TC;
                        state   <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (clk_cnt != '0) begin
                        clk_cnt <= clk_cnt - CW'(1);
                    end else if (!rx_s) begin
                        // A low stop bit outranks any parity result.
                        frame_err <= 1'b1;
                        state     <= ST_WAIT_HIGH;
`ifdef UART_RX32_PARITY_EN
                    end else if ((^shreg) != par_bit) begin
                        par_err_q <= 1'b1;
                        state     <= ST_IDLE;
`endif
                    end else begin
                        rx_data <= shreg;
                        rx_done <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end
                ST_WAIT_HIGH: begin
                    if (rx_s) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign rx_busy = (state != ST_IDLE) && (state != ST_WAIT_HIGH);

`ifdef UART_RX32_PARITY_EN
    assign parity_err = par_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx32.sv
// Self-checking bench for uart_rx32 with CLKS_PER_BIT=16 and a frame-level reference model.
module tb_uart_rx32;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;
`ifdef UART_RX32_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    // rx driven on a negedge reaches the FSM 3 posedges later; result follows the stop sample.
    localparam int LAT = 3 + HALF + (PAR_EN ? 34 : 33) * CPB;

    localparam int EV_DONE = 0;
    localparam int EV_FERR = 1;
    localparam int EV_PERR = 2;

    logic        PCLK = 1'b0;
    logic        PRESET = 1'b0;
    logic        rx = 1'b1;
    logic [31:0] rx_data;
    logic        rx_done;
    logic        rx_busy;
    logic        frame_err;
    logic        parity_err;

    uart_rx32 #(.CLKS_PER_BIT(CPB)) dut (
        .PCLK       (PCLK),
        .PRESET     (PRESET),
        .rx         (rx),
        .rx_data    (rx_data),
        .rx_done    (rx_done),
        .rx_busy    (rx_busy),
        .frame_err  (frame_err),
        .parity_err (parity_err)
    );

    always #5 PCLK = ~PCLK;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int          obs_kind[$];
    logic [31:0] obs_data[$];
    int          obs_cyc[$];
    int          exp_kind[$];
    logic [31:0] exp_data[$];

    logic [31:0] last_good = 32'h0;
    logic [31:0] prev_data = 32'h0;
    logic        prev_busy = 1'b0;
    int overlap_cnt  = 0;
    int data_chg_bad = 0;
    int busy_rise    = -1;
    int busy_fall    = -1;

    always @(posedge PCLK) cyc++;

    always @(negedge PCLK) begin
        if (int'(rx_done) + int'(frame_err) + int'(parity_err) > 1) overlap_cnt++;
        if (rx_done === 1'b1)    begin obs_kind.push_back(EV_DONE); obs_data.push_back(rx_data); obs_cyc.push_back(cyc); end
        if (frame_err === 1'b1)  begin obs_kind.push_back(EV_FERR); obs_data.push_back(rx_data); obs_cyc.push_back(cyc); end
        if (parity_err === 1'b1) begin obs_kind.push_back(EV_PERR); obs_data.push_back(rx_data); obs_cyc.push_back(cyc); end
        if (!PRESET && rx_data !== prev_data && rx_done !== 1'b1) data_chg_bad++;
        if (rx_busy === 1'b1 && !prev_busy) busy_rise = cyc;
        if (rx_busy === 1'b0 && prev_busy)  busy_fall = cyc;
        prev_data = rx_data;
        prev_busy = (rx_busy === 1'b1);
    end

    task automatic clear_queues();
        obs_kind.delete(); obs_data.delete(); obs_cyc.delete();
        exp_kind.delete(); exp_data.delete();
        busy_rise = -1;
        busy_fall = -1;
    endtask

    // Reference model: outcome of one whole frame from the framing rules.
    task automatic model_frame(input logic [31:0] w, input logic stop, input logic par);
        if (!stop) begin
            exp_kind.push_back(EV_FERR); exp_data.push_back(last_good);
        end else if (PAR_EN && (par !== (^w))) begin
            exp_kind.push_back(EV_PERR); exp_data.push_back(last_good);
        end else begin
            last_good = w;
            exp_kind.push_back(EV_DONE); exp_data.push_back(w);
        end
    endtask

    // Called at a negedge; returns at a negedge with rx left at the stop level.
    task automatic send_frame(input logic [31:0] w, input logic stop, input logic par,
                              output int start_cyc);
        start_cyc = cyc;
        rx = 1'b0;
        repeat (CPB) @(negedge PCLK);
        for (int i = 0; i < 32; i++) begin
            rx = w[i];
            repeat (CPB) @(negedge PCLK);
        end
`ifdef UART_RX32_PARITY_EN
        rx = par;
        repeat (CPB) @(negedge PCLK);
`endif
        rx = stop;
        repeat (CPB) @(negedge PCLK);
    endtask

    task automatic test_reset();
        #1 PRESET = 1'b1;
        repeat (3) @(negedge PCLK);
        n_checks++; if (rx_data !== 32'h0)  begin n_fail++; $display("FAIL reset_rx_data: got %h, expected 0", rx_data); end
        n_checks++; if (rx_done !== 1'b0)   begin n_fail++; $display("FAIL reset_rx_done: got %b, expected 0", rx_done); end
        n_checks++; if (rx_busy !== 1'b0)   begin n_fail++; $display("FAIL reset_rx_busy: got %b, expected 0", rx_busy); end
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b, expected 0", frame_err); end
        n_checks++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL reset_parity_err: got %b, expected 0", parity_err); end
        PRESET = 1'b0;
        repeat (4) @(negedge PCLK);
    endtask

    task automatic test_basic();
        int sc;
        logic [31:0] w = 32'h12345678;
        clear_queues();
        send_frame(w, 1'b1, ^w, sc);
        model_frame(w, 1'b1, ^w);
        repeat (4) @(negedge PCLK);
        n_checks++;
        if (obs_cyc.size() < 1 || obs_cyc[0] - sc !== LAT) begin
            n_fail++; $display("FAIL basic_latency: got %0d, expected %0d",
                               (obs_cyc.size() > 0) ? obs_cyc[0] - sc : -1, LAT);
        end
        n_checks++;
        if (busy_rise - sc !== 3) begin n_fail++; $display("FAIL basic_busy_rise: got %0d, expected 3", busy_rise - sc); end
        n_checks++;
        if (obs_cyc.size() < 1 || busy_fall !== obs_cyc[0]) begin
            n_fail++; $display("FAIL basic_busy_fall: got cycle %0d, expected %0d", busy_fall,
                               (obs_cyc.size() > 0) ? obs_cyc[0] : -1);
        end
        n_checks++;
        if (obs_kind.size() !== exp_kind.size()) begin n_fail++; $display("FAIL basic_count: got %0d events, expected %0d", obs_kind.size(), exp_kind.size()); end
        foreach (exp_kind[i]) if (i < obs_kind.size()) begin
            n_checks++;
            if (obs_kind[i] !== exp_kind[i] || obs_data[i] !== exp_data[i]) begin
                n_fail++; $display("FAIL basic_event%0d: got kind %0d data %h, expected kind %0d data %h", i, obs_kind[i], obs_data[i], exp_kind[i], exp_data[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int sc;
        logic [31:0] w0 = 32'hFFFFFFFF;
        logic [31:0] w1 = 32'h00000001;
        clear_queues();
        send_frame(w0, 1'b1, ^w0, sc); model_frame(w0, 1'b1, ^w0);
        send_frame(w1, 1'b1, ^w1, sc); model_frame(w1, 1'b1, ^w1);
        repeat (4) @(negedge PCLK);
        n_checks++;
        if (obs_kind.size() !== exp_kind.size()) begin n_fail++; $display("FAIL b2b_count: got %0d events, expected %0d", obs_kind.size(), exp_kind.size()); end
        foreach (exp_kind[i]) if (i < obs_kind.size()) begin
            n_checks++;
            if (obs_kind[i] !== exp_kind[i] || obs_data[i] !== exp_data[i]) begin
                n_fail++; $display("FAIL b2b_event%0d: got kind %0d data %h, expected kind %0d data %h", i, obs_kind[i], obs_data[i], exp_kind[i], exp_data[i]);
            end
        end
    endtask

    task automatic test_glitch();
        clear_queues();
        rx = 1'b0;
        repeat (4) @(negedge PCLK);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge PCLK);
        n_checks++; if (obs_kind.size() !== 0) begin n_fail++; $display("FAIL glitch_events: got %0d, expected 0", obs_kind.size()); end
        n_checks++; if (rx_busy !== 1'b0)      begin n_fail++; $display("FAIL glitch_busy: got %b, expected 0", rx_busy); end
        n_checks++; if (rx_data !== last_good) begin n_fail++; $display("FAIL glitch_rx_data: got %h, expected %h", rx_data, last_good); end
    endtask

    task automatic test_framing();
        int sc;
        int busy_hi = 0;
        logic [31:0] w0 = 32'hA5A5A5A5;
        logic [31:0] w1 = 32'h0000BEEF;
        clear_queues();
        send_frame(w0, 1'b0, ^w0, sc); model_frame(w0, 1'b0, ^w0);
        repeat (100) begin
            @(negedge PCLK);
            if (rx_busy !== 1'b0) busy_hi++;
        end
        n_checks++; if (busy_hi !== 0) begin n_fail++; $display("FAIL framing_hold_busy: got %0d busy cycles, expected 0", busy_hi); end
        rx = 1'b1;
        repeat (8) @(negedge PCLK);
        send_frame(w1, 1'b1, ^w1, sc); model_frame(w1, 1'b1, ^w1);
        repeat (4) @(negedge PCLK);
        n_checks++;
        if (obs_kind.size() !== exp_kind.size()) begin n_fail++; $display("FAIL framing_count: got %0d events, expected %0d", obs_kind.size(), exp_kind.size()); end
        foreach (exp_kind[i]) if (i < obs_kind.size()) begin
            n_checks++;
            if (obs_kind[i] !== exp_kind[i] || obs_data[i] !== exp_data[i]) begin
                n_fail++; $display("FAIL framing_event%0d: got kind %0d data %h, expected kind %0d data %h", i, obs_kind[i], obs_data[i], exp_kind[i], exp_data[i]);
            end
        end
    endtask

    task automatic test_reset_midframe();
        int sc;
        logic [31:0] w0 = 32'hDEADBEEF;
        logic [31:0] w1 = 32'hCAFEF00D;
        clear_queues();
        rx = 1'b0;
        repeat (CPB) @(negedge PCLK);
        for (int i = 0; i < 10; i++) begin
            rx = w0[i];
            repeat (CPB) @(negedge PCLK);
        end
        rx = w0[10];
        repeat (HALF) @(negedge PCLK);
        PRESET = 1'b1;
        #1;
        n_checks++; if (rx_busy !== 1'b0)  begin n_fail++; $display("FAIL midreset_busy: got %b, expected 0", rx_busy); end
        n_checks++; if (rx_data !== 32'h0) begin n_fail++; $display("FAIL midreset_rx_data: got %h, expected 0", rx_data); end
        repeat (3) @(negedge PCLK);
        PRESET = 1'b0;
        rx = 1'b1;
        last_good = 32'h0;
        repeat (2 * CPB) @(negedge PCLK);
        send_frame(w1, 1'b1, ^w1, sc); model_frame(w1, 1'b1, ^w1);
        repeat (4) @(negedge PCLK);
        n_checks++;
        if (obs_kind.size() !== exp_kind.size()) begin n_fail++; $display("FAIL midreset_count: got %0d events, expected %0d", obs_kind.size(), exp_kind.size()); end
        foreach (exp_kind[i]) if (i < obs_kind.size()) begin
            n_checks++;
            if (obs_kind[i] !== exp_kind[i] || obs_data[i] !== exp_data[i]) begin
                n_fail++; $display("FAIL midreset_event%0d: got kind %0d data %h, expected kind %0d data %h", i, obs_kind[i], obs_data[i], exp_kind[i], exp_data[i]);
            end
        end
    endtask

`ifdef UART_RX32_PARITY_EN
    task automatic test_parity();
        int sc;
        logic [31:0] w = 32'h00000007;
        clear_queues();
        send_frame(w, 1'b1, 1'b1, sc); model_frame(w, 1'b1, 1'b1);
        send_frame(w, 1'b1, 1'b0, sc); model_frame(w, 1'b1, 1'b0);
        send_frame(w, 1'b0, 1'b0, sc); model_frame(w, 1'b0, 1'b0);
        rx = 1'b1;
        repeat (8) @(negedge PCLK);
        n_checks++;
        if (obs_kind.size() !== exp_kind.size()) begin n_fail++; $display("FAIL parity_count: got %0d events, expected %0d", obs_kind.size(), exp_kind.size()); end
        foreach (exp_kind[i]) if (i < obs_kind.size()) begin
            n_checks++;
            if (obs_kind[i] !== exp_kind[i] || obs_data[i] !== exp_data[i]) begin
                n_fail++; $display("FAIL parity_event%0d: got kind %0d data %h, expected kind %0d data %h", i, obs_kind[i], obs_data[i], exp_kind[i], exp_data[i]);
            end
        end
    endtask
`endif

    task automatic test_random();
        int sc;
        logic [31:0] w;
        logic stop, par;
        clear_queues();
        for (int n = 0; n < 10; n++) begin
            w    = $urandom;
            stop = ($urandom_range(0, 3) != 0);
            par  = ($urandom_range(0, 3) != 0) ? (^w) : ~(^w);
            send_frame(w, stop, par, sc);
            model_frame(w, stop, par);
            rx = 1'b1;
            repeat (stop ? $urandom_range(0, 6) : $urandom_range(4, 10)) @(negedge PCLK);
        end
        repeat (4) @(negedge PCLK);
        n_checks++;
        if (obs_kind.size() !== exp_kind.size()) begin n_fail++; $display("FAIL random_count: got %0d events, expected %0d", obs_kind.size(), exp_kind.size()); end
        foreach (exp_kind[i]) if (i < obs_kind.size()) begin
            n_checks++;
            if (obs_kind[i] !== exp_kind[i] || obs_data[i] !== exp_data[i]) begin
                n_fail++; $display("FAIL random_event%0d: got kind %0d data %h, expected kind %0d data %h", i, obs_kind[i], obs_data[i], exp_kind[i], exp_data[i]);
            end
        end
        n_checks++; if (rx_data !== last_good) begin n_fail++; $display("FAIL random_final_data: got %h, expected %h", rx_data, last_good); end
    endtask

    task automatic test_invariants();
        n_checks++; if (overlap_cnt !== 0)  begin n_fail++; $display("FAIL pulse_overlap: got %0d cycles, expected 0", overlap_cnt); end
        n_checks++; if (data_chg_bad !== 0) begin n_fail++; $display("FAIL rx_data_stray_change: got %0d, expected 0", data_chg_bad); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_glitch();
        test_framing();
        test_reset_midframe();
`ifdef UART_RX32_PARITY_EN
        test_parity();
`endif
        test_random();
        test_invariants();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx32.md
# uart_rx32

32-bit-word UART receiver. It deserialises frames with one start bit, 32 data bits LSB first and one stop bit from the serial line `rx`. It presents each completed word, with a one-cycle strobe, on the `fromrx`/`rxdone` inputs of the APB slave in `master_slave`. It is the receive counterpart of the UART transmit path fed by `totx`.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 1042: PCLK cycles per serial bit (10 MHz / 9600 baud). Must be at least 8.

Ports:
- `PCLK` in 1: system clock; all state updates on the rising edge.
- `PRESET` in 1: asynchronous, active-high reset.
- `rx` in 1: serial input, idle high; asynchronous to PCLK.
- `rx_data` out 32: last good word. Reset value 0.
- `rx_done` out 1: one-cycle pulse when `rx_data` is updated. Reset value 0.
- `rx_busy` out 1: high in every state except IDLE and WAIT_HIGH. Reset value 0.
- `frame_err` out 1: one-cycle pulse when the stop bit is sampled low. Reset value 0.
- `parity_err` out 1: one-cycle pulse on parity mismatch. Constant 0 without the macro. Reset value 0.

## Operation
- `rx` passes through a 2-flop synchroniser to give `rx_s`. Both flops reset to 1. All logic uses `rx_s` only.
- One bit counter (6 bits) and one clock counter (wide enough for `CLKS_PER_BIT`-1). HALF = `CLKS_PER_BIT`/2, using integer division.
- States:
  - IDLE: when `rx_s`=0, load the clock counter, go to START.
  - START: after HALF cycles, sample `rx_s`. If 1 (glitch), return to IDLE with no pulse. If 0, go to DATA with bit counter 0.
  - DATA: every `CLKS_PER_BIT` cycles, sample `rx_s` into shift register bit [bitcnt]. After bit 31, go to PARITY (macro on) or STOP.
  - PARITY: after `CLKS_PER_BIT` cycles, sample the parity bit, then go to STOP.
  - STOP: after `CLKS_PER_BIT` cycles, sample `rx_s`.
    - If 1 and parity is OK: load `rx_data`, pulse `rx_done`, go to IDLE.
    - If 1 and parity is bad: pulse `parity_err`, leave `rx_data` unchanged, go to IDLE.
    - If 0: pulse `frame_err`, leave `rx_data` unchanged, go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rx_s`=1, then go to IDLE. This stops a break condition from retriggering.
- `rx_data` changes only in the cycle `rx_done` rises. It holds its value otherwise, including after errors.
- At most one of `rx_done`, `frame_err` and `parity_err` is high in any cycle.
- A stop error takes priority over a parity error: a frame with both asserts only `frame_err`.

## Timing
- Let t0 be the PCLK edge at which IDLE first sees `rx_s`=0. The `rx` falling edge reaches `rx_s` 2–3 cycles after it occurs.
- Sample edges:
  - Start re-check: t0+HALF.
  - Data bit k (0..31): t0+HALF+(k+1)·`CLKS_PER_BIT`.
  - Parity: t0+HALF+33·`CLKS_PER_BIT`.
  - Stop: t0+HALF+33·`CLKS_PER_BIT` without the macro, t0+HALF+34·`CLKS_PER_BIT` with it.
- `rx_done`, `frame_err` and `parity_err` are registered. They are high for exactly the one cycle after the stop sample edge.
- `rx_busy` rises the cycle after t0. It falls in the same cycle the result pulse is high.
- Back-to-back frames: the receiver returns to IDLE at mid-stop-bit. A start bit that begins right after the stop bit is therefore caught with no lost frame.
- `PRESET` mid-frame: all outputs and the synchroniser return to reset values immediately. No pulse is issued for the partial frame. The next falling edge after release starts a fresh frame.

## Configuration
- `UART_RX32_PARITY_EN` defined:
  - The frame carries an even-parity bit between data bit 31 and the stop bit, making 35 bits total.
  - The PARITY state is present.
  - `parity_err` is driven as above.
- Not defined:
  - 34-bit frame with no PARITY state.
  - `parity_err` tied to 0.

## Test plan
- Use `CLKS_PER_BIT`=16 with ideal frames.
  - Send 32'h12345678. `rx_done` pulses once and `rx_data`=32'h12345678 in the same cycle; no error pulse.
  - Send 32'hFFFFFFFF then 32'h00000001 back-to-back with no idle gap. Two `rx_done` pulses, with `rx_data` equal to each word in turn.
- Glitch: drive `rx` low for 4 cycles, then high. No pulse, `rx_busy` returns to 0, and `rx_data` keeps its prior value.
- Framing: send 32'hA5A5A5A5 with the stop bit low and hold low for 100 cycles, then send 32'h0000BEEF normally. Expect:
  - One `frame_err` pulse and no `rx_done` for the first frame.
  - No retrigger during the low hold.
  - `rx_done` with `rx_data`=32'h0000BEEF for the second frame.
- Reset: assert `PRESET` at data bit 10 of 32'hDEADBEEF for 3 cycles, then send 32'hCAFEF00D. No pulse for the aborted frame; `rx_done` with 32'hCAFEF00D follows.
- With `UART_RX32_PARITY_EN`:
  - Send 32'h00000007 with parity bit 1 (correct) and expect `rx_done`.
  - Send it again with parity bit 0 and expect a `parity_err` pulse while `rx_data` stays 32'h00000007.
